// File: rtl/ifu_rf_rs1_arb_pkg.sv
// Shared definitions for the regfile read-port-1 arbiter: default widths,
// default starvation limit and the BPU transaction state encoding.
package ifu_rf_rs1_arb_pkg;

    localparam int ARB_XLEN        = 32;
    localparam int ARB_RFIDX_WIDTH = 5;
    localparam int ARB_STARVE_MAX  = 4;

    // BPU transaction phases: issue (IDLE), data return (WAIT), buffered (HOLD)
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_HOLD = 2'd2
    } arb_state_e;

endpackage

// File: rtl/ifu_rf_arb_starve_cnt.sv
// Saturating counter of consecutive BPU arbitration losses. at_max tells the
// arbiter to give the BPU forced priority over the EXU.
module ifu_rf_arb_starve_cnt #(
    parameter int STARVE_MAX = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic clr,
    output logic at_max
);
    localparam int CW = $clog2(STARVE_MAX + 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign at_max = (cnt_q == CW'(STARVE_MAX));

    // Clear has priority over increment; increment stops at STARVE_MAX
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && !at_max) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Counter register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/ifu_rf_rs1_arb.sv
// Regfile read port 1 arbiter between the IFU BPU (JALR rs1 fetch) and the
// EXU IR-stage operand read. The BPU read is buffered in a hold register so
// the port is only used for one cycle per BPU transaction.
// Optional build macro: BPU_RS1_X0_BYPASS_EN -- a BPU read of x0 is granted
// immediately from IDLE without touching the regfile port.
module ifu_rf_rs1_arb
    import ifu_rf_rs1_arb_pkg::*;
#(
    parameter int XLEN        = ARB_XLEN,
    parameter int RFIDX_WIDTH = ARB_RFIDX_WIDTH,
    parameter int STARVE_MAX  = ARB_STARVE_MAX
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   bpu_req,
    input  logic [RFIDX_WIDTH-1:0] bpu_rs1idx,
    output logic                   bpu_gnt,
    output logic                   bpu_rdata_vld,
    output logic [XLEN-1:0]        bpu_rdata,
    input  logic                   bpu_rdata_ack,
    input  logic                   exu_req,
    input  logic [RFIDX_WIDTH-1:0] exu_rs1idx,
    output logic                   exu_gnt,
    output logic                   exu_rdata_vld,
    output logic [XLEN-1:0]        exu_rdata,
    output logic                   rf_rd_ena,
    output logic [RFIDX_WIDTH-1:0] rf_rd_idx,
    input  logic [XLEN-1:0]        rf_rd_data
);

    arb_state_e      state_q;
    arb_state_e      state_d;
    logic [XLEN-1:0] hold_q;
    logic [XLEN-1:0] hold_d;
    logic            rsp_owner_q;

    logic bpu_gnt_c;     // BPU granted this cycle (port or bypass)
    logic bpu_port_c;    // BPU granted and occupies the regfile port
    logic bpu_port;
    logic at_max;
    logic starve_inc;
    logic starve_clr;

    // Next-state logic of the BPU transaction sequencer
    always_comb begin
        state_d    = state_q;
        hold_d     = hold_q;
        bpu_gnt_c  = 1'b0;
        bpu_port_c = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bpu_req && !flush) begin
`ifdef BPU_RS1_X0_BYPASS_EN
                    if (bpu_rs1idx == '0) begin
                        bpu_gnt_c = 1'b1;
                        hold_d    = '0;
                        state_d   = ST_HOLD;
                    end else
`endif
                    if (!exu_req || at_max) begin
                        bpu_gnt_c  = 1'b1;
                        bpu_port_c = 1'b1;
                        state_d    = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                // A flush drops the returning data on the floor
                if (flush) begin
                    state_d = ST_IDLE;
                end else begin
                    hold_d  = rf_rd_data;
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                // No new grant in the ack cycle: IDLE is only entered next cycle
                if (bpu_rdata_ack || flush) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Grants are masked while reset is asserted so all outputs read zero at once
    assign bpu_port      = bpu_port_c & ~rst;
    assign bpu_gnt       = bpu_gnt_c & ~rst;
    assign exu_gnt       = exu_req & ~bpu_port_c & ~rst;
    assign rf_rd_ena     = bpu_port | exu_gnt;
    assign rf_rd_idx     = rst ? '0 : (bpu_port ? bpu_rs1idx : exu_rs1idx);

    assign bpu_rdata_vld = (state_q == ST_HOLD);
    assign bpu_rdata     = hold_q;
    assign exu_rdata_vld = rsp_owner_q;
    assign exu_rdata     = rst ? '0 : rf_rd_data;

    // BPU loses only when it is waiting in IDLE and the EXU took the port
    assign starve_inc = (state_q == ST_IDLE) & bpu_req & ~flush & exu_gnt;
    assign starve_clr = bpu_gnt | flush;

    ifu_rf_arb_starve_cnt #(
        .STARVE_MAX (STARVE_MAX)
    ) u_starve_cnt (
        .clk    (clk),
        .rst    (rst),
        .inc    (starve_inc),
        .clr    (starve_clr),
        .at_max (at_max)
    );

    // State, hold buffer and response-owner registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            hold_q      <= '0;
            rsp_owner_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            rsp_owner_q <= exu_gnt;
        end
    end

endmodule

// File: tb/tb_ifu_rf_rs1_arb.sv
// Randomized scoreboard bench for ifu_rf_rs1_arb. A transaction-level model
// predicts grants and pushes expected read data into queues; a separate
// monitor compares DUT outputs on the falling edge.
module tb_ifu_rf_rs1_arb;
    import ifu_rf_rs1_arb_pkg::*;

    localparam int XL = 32;
    localparam int IW = 5;
    localparam int SM = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          flush = 1'b0;
    logic          bpu_req = 1'b0;
    logic [IW-1:0] bpu_rs1idx = '0;
    logic          bpu_gnt;
    logic          bpu_rdata_vld;
    logic [XL-1:0] bpu_rdata;
    logic          bpu_rdata_ack = 1'b0;
    logic          exu_req = 1'b0;
    logic [IW-1:0] exu_rs1idx = '0;
    logic          exu_gnt;
    logic          exu_rdata_vld;
    logic [XL-1:0] exu_rdata;
    logic          rf_rd_ena;
    logic [IW-1:0] rf_rd_idx;
    logic [XL-1:0] rf_rd_data = '0;

    logic [XL-1:0] regs [32];
    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    ifu_rf_rs1_arb #(.XLEN(XL), .RFIDX_WIDTH(IW), .STARVE_MAX(SM)) dut (
        .clk           (clk),
        .rst           (rst),
        .flush         (flush),
        .bpu_req       (bpu_req),
        .bpu_rs1idx    (bpu_rs1idx),
        .bpu_gnt       (bpu_gnt),
        .bpu_rdata_vld (bpu_rdata_vld),
        .bpu_rdata     (bpu_rdata),
        .bpu_rdata_ack (bpu_rdata_ack),
        .exu_req       (exu_req),
        .exu_rs1idx    (exu_rs1idx),
        .exu_gnt       (exu_gnt),
        .exu_rdata_vld (exu_rdata_vld),
        .exu_rdata     (exu_rdata),
        .rf_rd_ena     (rf_rd_ena),
        .rf_rd_idx     (rf_rd_idx),
        .rf_rd_data    (rf_rd_data)
    );

    // Regfile: one-cycle registered read
    always @(posedge clk) begin
        if (rf_rd_ena) rf_rd_data <= regs[rf_rd_idx];
    end

    // ---------------- reference model ----------------
    typedef struct {
        logic [XL-1:0] data;
        int            due;
    } rsp_t;

    rsp_t          exu_q[$];
    logic [XL-1:0] bpu_q[$];

    int  cyc = 0;
    bit  busy = 0;        // a BPU transaction is outstanding
    int  ready_cyc = 0;   // first cycle its data is visible
    int  losses = 0;      // consecutive cycles the BPU lost to the EXU
    bit  e_rst = 1, e_bpu_gnt = 0, e_port_bpu = 0, e_exu_gnt = 0;
    bit  e_bpu_vld = 0, e_retire = 0;

    always @(posedge clk) begin
        bit x0;
        bit was_busy;
        #2;
        cyc++;
        if (rst) begin
            e_rst = 1; e_bpu_gnt = 0; e_port_bpu = 0; e_exu_gnt = 0;
            e_bpu_vld = 0; e_retire = 0;
            busy = 0; losses = 0;
            exu_q.delete();
            bpu_q.delete();
        end else begin
            e_rst = 0;
            x0 = 0;
`ifdef BPU_RS1_X0_BYPASS_EN
            x0 = (bpu_rs1idx == '0);
`endif
            was_busy   = busy;
            e_bpu_vld  = busy && (cyc >= ready_cyc);
            e_bpu_gnt  = !busy && bpu_req && !flush && (x0 || !exu_req || losses == SM);
            e_port_bpu = e_bpu_gnt && !x0;
            e_exu_gnt  = exu_req && !e_port_bpu;
            e_retire   = 0;
            if (busy && (flush || (e_bpu_vld && bpu_rdata_ack))) begin
                busy = 0;
                e_retire = 1;
            end
            if (e_bpu_gnt) begin
                busy = 1;
                ready_cyc = cyc + (x0 ? 1 : 2);
                bpu_q.push_back(x0 ? '0 : regs[bpu_rs1idx]);
            end
            if (e_bpu_gnt || flush) losses = 0;
            else if (!was_busy && bpu_req && e_exu_gnt && losses < SM) losses++;
            if (e_exu_gnt) exu_q.push_back('{regs[exu_rs1idx], cyc + 1});
        end
    end

    // ---------------- monitor ----------------
    task automatic chk(input string name, input logic [XL-1:0] act, input logic [XL-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
        end
    endtask

    always @(negedge clk) begin
        rsp_t r;
        if (e_rst) begin
            chk("rst_bpu_gnt", XL'(bpu_gnt), '0);
            chk("rst_exu_gnt", XL'(exu_gnt), '0);
            chk("rst_rf_rd_ena", XL'(rf_rd_ena), '0);
            chk("rst_bpu_vld", XL'(bpu_rdata_vld), '0);
            chk("rst_exu_vld", XL'(exu_rdata_vld), '0);
            chk("rst_bpu_rdata", bpu_rdata, '0);
        end else begin
            chk("bpu_gnt", XL'(bpu_gnt), XL'(e_bpu_gnt));
            chk("exu_gnt", XL'(exu_gnt), XL'(e_exu_gnt));
            chk("rf_rd_ena", XL'(rf_rd_ena), XL'(e_port_bpu | e_exu_gnt));
            if (e_port_bpu) chk("rf_idx_bpu", XL'(rf_rd_idx), XL'(bpu_rs1idx));
            else if (e_exu_gnt) chk("rf_idx_exu", XL'(rf_rd_idx), XL'(exu_rs1idx));
            chk("bpu_vld", XL'(bpu_rdata_vld), XL'(e_bpu_vld));
            if (e_bpu_vld) begin
                if (bpu_q.size() == 0) chk("bpu_q_empty", XL'(1), '0);
                else chk("bpu_rdata", bpu_rdata, bpu_q[0]);
            end
            if (e_retire && bpu_q.size() > 0) void'(bpu_q.pop_front());
            if (exu_q.size() > 0 && exu_q[0].due == cyc) begin
                r = exu_q.pop_front();
                chk("exu_vld", XL'(exu_rdata_vld), XL'(1));
                if (exu_rdata_vld) chk("exu_rdata", exu_rdata, r.data);
            end else begin
                chk("exu_vld", XL'(exu_rdata_vld), XL'(0));
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bpu_req = 0; exu_req = 0; flush = 0; bpu_rdata_ack = 1; rst = 0;
        repeat (3) step();
        bpu_rdata_ack = 0;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) regs[i] = $urandom;
        regs[0] = '0;
        regs[5] = 32'h1234;
        regs[7] = 32'hBEEF;

        repeat (3) step();
        rst = 0;

        // BPU read of x5 on an idle port, EXU read of x7 while BPU holds
        step(); bpu_req = 1; bpu_rs1idx = 5;
        step(); bpu_req = 0;
        step(); exu_req = 1; exu_rs1idx = 7;
        step(); exu_req = 0;
        step(); bpu_rdata_ack = 1;
        step(); bpu_rdata_ack = 0;

        // Starvation: EXU back-to-back, BPU forced through on the 5th cycle
        step(); exu_req = 1; exu_rs1idx = 3; bpu_req = 1; bpu_rs1idx = 9;
        repeat (SM + 1) step();
        bpu_req = 0;
        repeat (3) step();
        idle_inputs();

        // Flush while the BPU data is in flight, then flush in IDLE
        step(); bpu_req = 1; bpu_rs1idx = 11;
        step(); bpu_req = 0; flush = 1;
        step(); flush = 0;
        step(); bpu_req = 1; exu_req = 1; flush = 1;
        step(); bpu_req = 0; exu_req = 0; flush = 0;
        step();

        // x0 request while the EXU also requests
        step(); bpu_req = 1; bpu_rs1idx = 0; exu_req = 1; exu_rs1idx = 7;
        step(); bpu_req = 0; exu_req = 0;
        step(); bpu_rdata_ack = 1;
        idle_inputs();

        // Reset while holding BPU data
        step(); bpu_req = 1; bpu_rs1idx = 12;
        step(); bpu_req = 0;
        step();
        step(); rst = 1;
        step();
        step(); rst = 0;
        step();

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            step();
            bpu_req       = ($urandom_range(0, 1) == 1);
            bpu_rs1idx    = ($urandom_range(0, 7) == 0) ? '0 : IW'($urandom_range(0, 31));
            exu_req       = ($urandom_range(0, 3) != 0);
            exu_rs1idx    = IW'($urandom_range(0, 31));
            flush         = ($urandom_range(0, 15) == 0);
            bpu_rdata_ack = ($urandom_range(0, 2) == 0);
            rst           = ($urandom_range(0, 199) == 0);
        end
        idle_inputs();
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
